// File: rtl/mips_pkg.sv
// Shared encodings for the data-memory path.
// Size codes and the sequencer state enum.
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 4-lane data bus: enables,
// store replication, load extraction/extension, alignment.
module dmem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    unique case (1'b1)
      (size == SIZE_BYTE): begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sgn & rd_byte[7]}}, rd_byte};
      end
      (size == SIZE_HALF): begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{sgn & rd_half[15]}}, rd_half};
        misaligned = addr_lo[0];
      end
      (size == SIZE_WORD): begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = rdata;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_sequencer.sv
// Load/store sequencer: req/ack data-memory bus, PC stall.
// Optional request watchdog enabled by DMEM_TIMEOUT_EN.
module data_mem_sequencer
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              mem_re_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_size_in,
  input  logic              signed_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              bus_req_out,
  output logic              bus_we_out,
  output logic [ADDR_W-1:0] bus_addr_out,
  output logic [3:0]        bus_be_out,
  output logic [DATA_W-1:0] bus_wdata_out,
  input  logic              bus_ack_in,
  input  logic [DATA_W-1:0] bus_rdata_in,
  output logic              stall_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              done_out,
  output logic              err_out
);

  dmem_state_t       state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        size_q;
  logic              sgn_q, we_q;
  logic              err_q, err_nx;
  logic              in_idle, in_req;
  logic              tmo;

  logic [1:0]        al_size, al_lo;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata, al_rdata;
  logic              al_mis;

  assign in_idle = (state == ST_IDLE);
  assign in_req  = (state == ST_REQ);

  // Live inputs are checked for alignment in IDLE; latched copy after.
  assign al_size = in_idle ? mem_size_in : size_q;
  assign al_lo   = in_idle ? addr_in[1:0] : addr_q[1:0];

  dmem_lane_align u_align (
    .size       (al_size),
    .addr_lo    (al_lo),
    .sgn        (sgn_q),
    .wdata      (wdata_q),
    .rdata      (bus_rdata_in),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt;

  assign tmo = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)        cnt <= '0;
    else if (!in_req)     cnt <= '0;
    else if (!bus_ack_in) cnt <= cnt + 1'b1;
  end
`else
  // No watchdog: REQ waits for ack indefinitely.
  assign tmo = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_nx  = state;
    err_nx    = err_q;
    stall_out = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mem_re_in | mem_we_in) begin
          stall_out = 1'b1;
          state_nx  = ST_DONE;
          err_nx    = 1'b1;
          if ((mem_re_in ^ mem_we_in) && !al_mis) begin
            state_nx = ST_REQ;
            err_nx   = 1'b0;
          end
        end
      end
      ST_REQ: begin
        stall_out = 1'b1;
        if (bus_ack_in) begin
          state_nx = ST_DONE;
          err_nx   = 1'b0;
        end else if (tmo) begin
          state_nx = ST_DONE;
          err_nx   = 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        err_nx   = 1'b0;
      end
      default: begin
        state_nx = ST_IDLE;
        err_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state   <= ST_IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_BYTE;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      err_q   <= err_nx;
      rdata_q <= (in_req && bus_ack_in && !we_q) ? al_rdata : '0;
      if (in_idle && (mem_re_in ^ mem_we_in)) begin
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
        size_q  <= mem_size_in;
        sgn_q   <= signed_in;
        we_q    <= mem_we_in;
      end
    end
  end

  assign bus_req_out   = in_req;
  assign bus_we_out    = in_req & we_q;
  assign bus_addr_out  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be_out    = in_req ? al_be : 4'b0000;
  assign bus_wdata_out = in_req ? al_wdata : '0;
  assign done_out      = (state == ST_DONE);
  assign err_out       = done_out & err_q;
  assign rdata_out     = rdata_q;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Directed vector bench for data_mem_sequencer.
// Table of accesses plus reset/timeout/stray-ack sequences.
module tb_data_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we, sgn, ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata_bus;
  logic        req, bwe, stall, done, err;
  logic [31:0] baddr, bwdata, rdata;
  logic [3:0]  be;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_sequencer #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .mem_re_in     (re),
    .mem_we_in     (we),
    .mem_size_in   (size),
    .signed_in     (sgn),
    .addr_in       (addr),
    .wdata_in      (wdata),
    .bus_req_out   (req),
    .bus_we_out    (bwe),
    .bus_addr_out  (baddr),
    .bus_be_out    (be),
    .bus_wdata_out (bwdata),
    .bus_ack_in    (ack),
    .bus_rdata_in  (rdata_bus),
    .stall_out     (stall),
    .rdata_out     (rdata),
    .done_out      (done),
    .err_out       (err)
  );

  typedef struct {
    string       name;
    logic        re, we, sgn;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    int          ack_at;
    logic        x_bus;
    logic        x_err;
    logic [3:0]  x_be;
    logic [31:0] x_addr, x_wdata, x_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(vec_t v);
    int n;
    int stalls;
    stalls = 0;
    @(posedge clk); #1;
    re = v.re; we = v.we; sgn = v.sgn; size = v.size;
    addr = v.addr; wdata = v.wdata; ack = 1'b0;
    @(negedge clk);
    chk({v.name, " idle_req"}, req, 0);
    if (stall) stalls++;
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
    if (v.x_bus) begin
      n = 0;
      while (n <= v.ack_at && n < 50) begin
        ack = (n == v.ack_at);
        rdata_bus = v.rdata;
        @(negedge clk);
        if (stall) stalls++;
        chk({v.name, " req"}, req, 1);
        chk({v.name, " done_early"}, done, 0);
        chk({v.name, " we"}, bwe, v.we);
        chk({v.name, " addr"}, baddr, v.x_addr);
        chk({v.name, " be"}, be, v.x_be);
        chk({v.name, " wdata"}, bwdata, v.x_wdata);
        @(posedge clk); #1;
        ack = 1'b0;
        n++;
      end
    end
    @(negedge clk);
    chk({v.name, " done"}, done, 1);
    chk({v.name, " err"}, err, v.x_err);
    chk({v.name, " rdata"}, rdata, v.x_rdata);
    chk({v.name, " done_stall"}, stall, 0);
    chk({v.name, " done_req"}, req, 0);
    chk({v.name, " stalls"}, stalls, v.x_bus ? v.ack_at + 2 : 1);
    @(posedge clk); #1;
    chk({v.name, " done_pulse"}, done, 0);
  endtask

  initial begin
    //        name    re we sg size   addr        wdata        rdata     ack bus er be       baddr        bwdata       rdata_out
    vecs[0]  = '{"lw",   1,0,0,2'b11,32'h100,32'h0,       32'hDEADBEEF,2,1,0,4'b1111,32'h100,32'h0,       32'hDEADBEEF};
    vecs[1]  = '{"lbs",  1,0,1,2'b00,32'h103,32'h0,       32'h80123456,0,1,0,4'b1000,32'h100,32'h0,       32'hFFFFFF80};
    vecs[2]  = '{"lbu",  1,0,0,2'b00,32'h103,32'h0,       32'h80123456,1,1,0,4'b1000,32'h100,32'h0,       32'h00000080};
    vecs[3]  = '{"sh",   0,1,0,2'b01,32'h202,32'h1234,    32'hAAAAAAAA,0,1,0,4'b1100,32'h200,32'h12341234,32'h0};
    vecs[4]  = '{"lhs",  1,0,1,2'b01,32'h102,32'h0,       32'h80010000,0,1,0,4'b1100,32'h100,32'h0,       32'hFFFF8001};
    vecs[5]  = '{"lhu",  1,0,0,2'b01,32'h100,32'h0,       32'h0000F00D,0,1,0,4'b0011,32'h100,32'h0,       32'h0000F00D};
    vecs[6]  = '{"sb",   0,1,0,2'b00,32'h101,32'h3A5,     32'h0,       0,1,0,4'b0010,32'h100,32'hA5A5A5A5,32'h0};
    vecs[7]  = '{"lbpos",1,0,1,2'b00,32'h101,32'h0,       32'h00007F00,0,1,0,4'b0010,32'h100,32'h0,       32'h0000007F};
    vecs[8]  = '{"sw",   0,1,0,2'b11,32'h10, 32'hCAFEF00D,32'h0,       3,1,0,4'b1111,32'h10, 32'hCAFEF00D,32'h0};
    vecs[9]  = '{"lwmis",1,0,0,2'b11,32'h101,32'h0,       32'h0,       0,0,1,4'b0000,32'h0,  32'h0,       32'h0};
    vecs[10] = '{"rewe", 1,1,0,2'b11,32'h100,32'h0,       32'h0,       0,0,1,4'b0000,32'h0,  32'h0,       32'h0};
    vecs[11] = '{"size2",1,0,0,2'b10,32'h100,32'h0,       32'h0,       0,0,1,4'b0000,32'h0,  32'h0,       32'h0};
    vecs[12] = '{"shmis",0,1,0,2'b01,32'h203,32'h1,       32'h0,       0,0,1,4'b0000,32'h0,  32'h0,       32'h0};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; re = 1'b0; we = 1'b0; sgn = 1'b0; ack = 1'b0;
    size = 2'b00; addr = '0; wdata = '0; rdata_bus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req", req, 0);
    chk("rst we", bwe, 0);
    chk("rst addr", baddr, 0);
    chk("rst be", be, 0);
    chk("rst wdata", bwdata, 0);
    chk("rst stall", stall, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst rdata", rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run(vecs[i]);

    // Ack while idle must not start or finish anything.
    @(posedge clk); #1;
    ack = 1'b1; rdata_bus = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stray_ack done", done, 0);
      chk("stray_ack req", req, 0);
      chk("stray_ack stall", stall, 0);
    end
    @(posedge clk); #1;
    ack = 1'b0;

    // Reset in the middle of a request.
    re = 1'b1; size = 2'b11; addr = 32'h300;
    @(posedge clk); #1;
    re = 1'b0;
    @(negedge clk);
    chk("mid_rst req_before", req, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst req", req, 0);
    chk("mid_rst stall", stall, 0);
    chk("mid_rst done", done, 0);
    @(negedge clk);
    chk("mid_rst done2", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(vecs[0]);

`ifdef DMEM_TIMEOUT_EN
    // No ack: aborted after four REQ cycles.
    @(posedge clk); #1;
    re = 1'b1; size = 2'b11; addr = 32'h40; ack = 1'b0;
    @(posedge clk); #1;
    re = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tmo req", req, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tmo done", done, 1);
    chk("tmo err", err, 1);
    chk("tmo req_drop", req, 0);
    chk("tmo rdata", rdata, 0);
    @(posedge clk); #1;
`else
    // No watchdog: request is held well past four cycles.
    @(posedge clk); #1;
    re = 1'b1; size = 2'b11; addr = 32'h40; ack = 1'b0;
    @(posedge clk); #1;
    re = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold req", req, 1);
      chk("hold done", done, 0);
      @(posedge clk); #1;
    end
    ack = 1'b1; rdata_bus = 32'h0BADF00D;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk("hold done_final", done, 1);
    chk("hold err", err, 0);
    chk("hold rdata", rdata, 32'h0BADF00D);
    @(posedge clk); #1;
`endif

    // Ack on the terminal REQ cycle completes without error.
    vecs[0].ack_at = 3;
    run(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
